// File: rtl/decode_queue_pkg.sv
// Shared decode constants: base opcodes, custom M-type {funct3, opcode} keys
// and the immediate-format encoding that execute also consumes.
package decode_queue_pkg;

  localparam logic [6:0] ITYPE_L = 7'b0000011;
  localparam logic [6:0] ITYPE_A = 7'b0010011;
  localparam logic [6:0] ITYPE_J = 7'b1100111;
  localparam logic [6:0] STYPE   = 7'b0100011;
  localparam logic [6:0] BTYPE   = 7'b1100011;
  localparam logic [6:0] UTYPE_L = 7'b0110111;
  localparam logic [6:0] UTYPE_U = 7'b0010111;
  localparam logic [6:0] JTYPE   = 7'b1101111;

  // Custom memory ops live in the custom-0/custom-1 opcode space, keyed with funct3
  localparam logic [9:0] MTYPE_L = {3'b010, 7'b0001011};
  localparam logic [9:0] MTYPE_S = {3'b010, 7'b0101011};

  typedef enum logic [2:0] {
    IMM_FMT_NONE = 3'd0,
    IMM_FMT_I    = 3'd1,
    IMM_FMT_S    = 3'd2,
    IMM_FMT_B    = 3'd3,
    IMM_FMT_U    = 3'd4,
    IMM_FMT_J    = 3'd5
  } imm_fmt_e;

endpackage

// File: rtl/decode_queue_imm_gen.sv
// Immediate generator: sign-extended immediate of a raw instruction word,
// zero when the instruction carries no immediate.
module decode_queue_imm_gen
  import decode_queue_pkg::*;
(
  input  logic [31:0] i_inst,
  output logic [31:0] o_imm
);

  logic [9:0]  w_f3op;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;

  assign w_f3op  = {i_inst[14:12], i_inst[6:0]};
  assign w_imm_i = {{20{i_inst[31]}}, i_inst[31:20]};
  assign w_imm_s = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
  assign w_imm_b = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
  assign w_imm_u = {i_inst[31:12], 12'h000};
  assign w_imm_j = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};

  // Select immediate by opcode; M-type keys are only tried after base opcodes miss
  always_comb begin
    o_imm = 32'h0000_0000;
    case (i_inst[6:0])
      ITYPE_L, ITYPE_A, ITYPE_J: o_imm = w_imm_i;
      STYPE:                     o_imm = w_imm_s;
      BTYPE:                     o_imm = w_imm_b;
      UTYPE_L, UTYPE_U:          o_imm = w_imm_u;
      JTYPE:                     o_imm = w_imm_j;
      default: begin
        if (w_f3op == MTYPE_L) begin
          o_imm = w_imm_i;
        end else if (w_f3op == MTYPE_S) begin
          o_imm = w_imm_s;
        end else begin
          o_imm = 32'h0000_0000;
        end
      end
    endcase
  end

endmodule

// File: rtl/decode_queue.sv
// Fetch-to-execute instruction buffer; each entry is pre-decoded at enqueue
// so execute sees a registered immediate and format.
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PC_W  = 32
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       flush_i,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PC_W-1:0]            in_pc,
  input  logic [31:0]                in_inst,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_W-1:0]            out_pc,
  output logic [31:0]                out_inst,
  output logic [31:0]                out_imm,
  output logic [2:0]                 out_imm_fmt,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Must mirror the decision order inside decode_queue_imm_gen
  function automatic imm_fmt_e fmt_of(input logic [31:0] inst);
    imm_fmt_e   f;
    logic [9:0] f3op;
    f3op = {inst[14:12], inst[6:0]};
    case (inst[6:0])
      ITYPE_L, ITYPE_A, ITYPE_J: f = IMM_FMT_I;
      STYPE:                     f = IMM_FMT_S;
      BTYPE:                     f = IMM_FMT_B;
      UTYPE_L, UTYPE_U:          f = IMM_FMT_U;
      JTYPE:                     f = IMM_FMT_J;
      default: begin
        if (f3op == MTYPE_L) begin
          f = IMM_FMT_I;
        end else if (f3op == MTYPE_S) begin
          f = IMM_FMT_S;
        end else begin
          f = IMM_FMT_NONE;
        end
      end
    endcase
    return f;
  endfunction

  logic [PC_W-1:0] r_pc   [DEPTH];
  logic [31:0]     r_inst [DEPTH];
  logic [31:0]     r_imm  [DEPTH];
  logic [2:0]      r_fmt  [DEPTH];

  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic            w_push;
  logic            w_pop;
  logic [31:0]     w_imm;

  decode_queue_imm_gen u_imm_gen (
    .i_inst (in_inst),
    .o_imm  (w_imm)
  );

  assign in_ready    = (r_count != FULL_CNT);
  assign out_valid   = (r_count != CW'(0));
  assign w_push      = in_valid && in_ready;
  assign w_pop       = out_valid && out_ready;

  assign out_pc      = r_pc[r_rd_ptr];
  assign out_inst    = r_inst[r_rd_ptr];
  assign out_imm     = r_imm[r_rd_ptr];
  assign out_imm_fmt = r_fmt[r_rd_ptr];
  assign count       = r_count;

  // Entry storage carries no reset; stale contents are hidden by count
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc[r_wr_ptr]   <= in_pc;
      r_inst[r_wr_ptr] <= in_inst;
      r_imm[r_wr_ptr]  <= w_imm;
      r_fmt[r_wr_ptr]  <= fmt_of(in_inst);
    end
  end

  // Pointer and occupancy control; reset beats flush, flush beats push/pop
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr <= PW'(0);
      r_rd_ptr <= PW'(0);
      r_count  <= CW'(0);
    end else if (flush_i) begin
      r_wr_ptr <= PW'(0);
      r_rd_ptr <= PW'(0);
      r_count  <= CW'(0);
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: directed scenarios followed by a
// randomized stream, all compared against a queue-based reference model.
module tb_decode_queue;
  import decode_queue_pkg::*;

  localparam int DEPTH = 2;
  localparam int PC_W  = 32;
  localparam int CW    = $clog2(DEPTH + 1);

  logic            clk = 1'b0;
  logic            rstn;
  logic            flush_i;
  logic            in_valid;
  logic            in_ready;
  logic [PC_W-1:0] in_pc;
  logic [31:0]     in_inst;
  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_pc;
  logic [31:0]     out_inst;
  logic [31:0]     out_imm;
  logic [2:0]      out_imm_fmt;
  logic [CW-1:0]   count;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;
  ent_t mq[$];

  decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .flush_i     (flush_i),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pc       (in_pc),
    .in_inst     (in_inst),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_inst    (out_inst),
    .out_imm     (out_imm),
    .out_imm_fmt (out_imm_fmt),
    .count       (count)
  );

  always #5 clk = ~clk;

  function automatic int m_fmt(input logic [31:0] i);
    logic [9:0] f3op;
    f3op = {i[14:12], i[6:0]};
    if (i[6:0] == ITYPE_L || i[6:0] == ITYPE_A || i[6:0] == ITYPE_J) return 1;
    if (i[6:0] == STYPE) return 2;
    if (i[6:0] == BTYPE) return 3;
    if (i[6:0] == UTYPE_L || i[6:0] == UTYPE_U) return 4;
    if (i[6:0] == JTYPE) return 5;
    if (f3op == MTYPE_L) return 1;
    if (f3op == MTYPE_S) return 2;
    return 0;
  endfunction

  // Immediate value as a signed integer assembled from the format's fields
  function automatic logic [31:0] m_imm(input logic [31:0] i);
    case (m_fmt(i))
      1:       return 32'($signed(i[31:20]));
      2:       return 32'($signed({i[31:25], i[11:7]}));
      3:       return 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      4:       return i & 32'hFFFF_F000;
      5:       return 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    chk("count", 32'(count), 32'(mq.size()));
    chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("out_pc", out_pc, mq[0].pc);
      chk("out_inst", out_inst, mq[0].inst);
      chk("out_imm", out_imm, m_imm(mq[0].inst));
      chk("out_imm_fmt", 32'(out_imm_fmt), 32'(m_fmt(mq[0].inst)));
    end
  endtask

  // One clock: drive at negedge, update model at posedge, check just after
  task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                     input logic rdy, input logic fl, input logic rst);
    logic push;
    logic pop;
    in_valid  = v;
    in_pc     = pc;
    in_inst   = inst;
    out_ready = rdy;
    flush_i   = fl;
    rstn      = ~rst;
    push = v && (mq.size() < DEPTH);
    pop  = rdy && (mq.size() != 0);
    @(posedge clk);
    if (rst || fl) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back('{pc: pc, inst: inst});
    end
    #1;
    check_state();
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 11))
      0:       r[6:0] = ITYPE_L;
      1:       r[6:0] = ITYPE_A;
      2:       r[6:0] = ITYPE_J;
      3:       r[6:0] = STYPE;
      4:       r[6:0] = BTYPE;
      5:       r[6:0] = UTYPE_L;
      6:       r[6:0] = UTYPE_U;
      7:       r[6:0] = JTYPE;
      8:       {r[14:12], r[6:0]} = MTYPE_L;
      9:       {r[14:12], r[6:0]} = MTYPE_S;
      10:      {r[14:12], r[6:0]} = {3'b111, 7'b0001011};
      default: r = r;
    endcase
    return r;
  endfunction

  initial begin
    logic        held;
    logic [31:0] h_pc;
    logic [31:0] h_inst;
    logic        v;
    logic        rdy;
    logic        fl;
    logic        rst;

    rstn = 1'b0; flush_i = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = 32'h0; in_inst = 32'h0;
    @(negedge clk);

    // Reset
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Single addi x1,x0,-1
    cyc(1'b1, 32'h100, 32'hFFF0_0093, 1'b0, 1'b0, 1'b0);
    chk("addi_valid", 32'(out_valid), 32'd1);
    chk("addi_imm", out_imm, 32'hFFFF_FFFF);
    chk("addi_fmt", 32'(out_imm_fmt), 32'd1);
    chk("addi_pc", out_pc, 32'h100);
    chk("addi_count", 32'(count), 32'd1);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    // sw then beq with back-pressure fills the queue
    cyc(1'b1, 32'h104, 32'h0011_2223, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h108, 32'hFE00_0EE3, 1'b0, 1'b0, 1'b0);
    chk("full_count", 32'(count), 32'd2);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("sw_imm", out_imm, 32'h0000_0004);
    chk("sw_fmt", 32'(out_imm_fmt), 32'd2);

    // Full with pop pending: one pop, no push; the held instruction enters next
    cyc(1'b1, 32'h10C, 32'h0050_0113, 1'b1, 1'b0, 1'b0);
    chk("fullpop_count", 32'(count), 32'd1);
    chk("beq_imm", out_imm, 32'hFFFF_FFFC);
    chk("beq_fmt", 32'(out_imm_fmt), 32'd3);
    cyc(1'b1, 32'h10C, 32'h0050_0113, 1'b0, 1'b0, 1'b0);
    chk("pending_accepted", 32'(count), 32'd2);

    // Flush with a simultaneous push drops everything
    cyc(1'b1, 32'h110, 32'h00A0_0193, 1'b0, 1'b1, 1'b0);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);

    // lui then jal streaming with out_ready=1
    cyc(1'b1, 32'h114, 32'h1234_52B7, 1'b1, 1'b0, 1'b0);
    chk("lui_imm", out_imm, 32'h1234_5000);
    chk("lui_fmt", 32'(out_imm_fmt), 32'd4);
    chk("lui_pc", out_pc, 32'h114);
    cyc(1'b1, 32'h118, 32'h0080_00EF, 1'b1, 1'b0, 1'b0);
    chk("jal_imm", out_imm, 32'h0000_0008);
    chk("jal_fmt", 32'(out_imm_fmt), 32'd5);
    chk("jal_count", 32'(count), 32'd1);

    // Ten-instruction stream across pointer wrap
    for (int k = 0; k < 10; k++) begin
      cyc(1'b1, 32'h200 + 32'(4 * k), {12'(k), 5'd0, 3'd0, 5'd1, 7'h13}, 1'b1, 1'b0, 1'b0);
      chk("stream_count", 32'(count), 32'd1);
      chk("stream_pc", out_pc, 32'h200 + 32'(4 * k));
      chk("stream_imm", out_imm, 32'(k));
    end

    // Reset mid-stream with one entry held
    cyc(1'b1, 32'h280, 32'h0010_0093, 1'b0, 1'b0, 1'b1);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    cyc(1'b1, 32'h300, 32'h0070_0093, 1'b0, 1'b0, 1'b0);
    chk("resume_pc", out_pc, 32'h300);
    chk("resume_imm", out_imm, 32'h0000_0007);

    // Randomized traffic; a refused instruction is held stable until taken
    held = 1'b0; h_pc = 32'h0; h_inst = 32'h0;
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      fl  = ($urandom_range(0, 15) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      if (held) begin
        v = 1'b1;
      end else begin
        v = ($urandom_range(0, 3) != 0);
        h_pc = $urandom & 32'hFFFF_FFFC;
        h_inst = rand_inst();
      end
      held = v && (mq.size() >= DEPTH) && !rst && !fl;
      cyc(v, h_pc, h_inst, rdy, fl, rst);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Small instruction buffer between fetch and execute; decouples fetch from back-pressure.
- Each accepted instruction is decoded by an imm_gen sub-instance at enqueue time. The entry stores {pc, inst, imm, imm_fmt}, so the execute stage sees a registered immediate.
- Valid/ready handshake on both sides; flush on branch/jump redirect.

Parameters:
- DEPTH, 2, number of entries; must be a power of two and at least 2.
- PC_W, 32, program-counter width.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rstn  input  1  synchronous reset, active-low.
- flush_i  input  1  discard all entries; asserted by execute on a redirect.
- in_valid  input  1  fetch presents an instruction.
- in_ready  output  1  queue can accept; equals !full.
- in_pc  input  PC_W  pc of the presented instruction.
- in_inst  input  32  raw instruction word.
- out_valid  output  1  head entry is valid; equals !empty.
- out_ready  input  1  execute consumes the head.
- out_pc  output  PC_W  head pc.
- out_inst  output  32  head instruction.
- out_imm  output  32  head immediate, sign-extended per format.
- out_imm_fmt  output  3  head format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J.
- count  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (rstn=0 at a rising edge):
  - wr_ptr, rd_ptr and count go to 0.
  - out_valid=0, in_ready=1.
  - Entry storage is not reset. out_pc, out_inst, out_imm and out_imm_fmt are don't-care while out_valid=0; the bench must not check them.
- Push: happens when in_valid && in_ready. The entry at wr_ptr is written with in_pc, in_inst, imm_gen(in_inst) and fmt(in_inst). wr_ptr then increments modulo DEPTH.
- Pop: happens when out_valid && out_ready. rd_ptr increments modulo DEPTH.
- Outputs are driven from the entry at rd_ptr. There is no combinational path from in_* to out_*.
  - Latency: an instruction pushed in cycle N is visible with out_valid=1 in cycle N+1 at the earliest.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop in the same cycle: unchanged; both pointers advance.
- Full (count==DEPTH):
  - in_ready=0.
  - A pop in the same cycle does not enable a push; in_ready does not depend on out_ready.
- Empty (count==0):
  - out_valid=0.
  - A push in the same cycle does not bypass to the output.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally. Full/empty are derived from count, never from pointer equality.
- Flush: when flush_i=1 at an edge, pointers and count go to 0.
  - Flush overrides any simultaneous push or pop; the pushed instruction is dropped.
  - The flushed state appears in the next cycle: out_valid=0, in_ready=1.
  - Reset has priority over flush.
- Format classification uses the opcode constants and follows the same decision order as imm_gen:
  - ItypeL, ItypeA, ItypeJ → I.
  - Stype → S.
  - Btype → B.
  - UtypeL, UtypeU → U.
  - Jtype → J.
  - {funct3, opcode} == MtypeL → I; == MtypeS → S.
  - Anything else → NONE, and imm is 0.
- Protocol rule: fetch must hold in_pc/in_inst stable while in_valid && !in_ready. The queue does not check this.
- Protocol rule: once out_valid=1, the head stays stable until it is popped or flushed.

Decomposition:
- Shared package:
  - The IMM_FMT_* encodings (3-bit) are added alongside the existing opcode and M-type constants in define.vh.
  - Execute uses the same encodings.
- Sub-module: reuse imm_gen as a single instance on the enqueue path.
- Classification: a local combinational fmt function; no other sub-modules.

Test Plan:
- Reset then single push of in_inst=0xFFF00093 (addi x1,x0,-1), pc=0x100:
  - Next cycle: out_valid=1, out_imm=0xFFFFFFFF, fmt=1, out_pc=0x100, count=1.
- Push 0x00112223 (sw x1,4(x2)), then 0xFE000EE3 (beq -4), out_ready=0:
  - Count reaches 2, in_ready=0.
  - Head imm=0x00000004 with fmt=2.
  - After one pop: imm=0xFFFFFFFC with fmt=3.
- Continuous stream with out_ready=1 of 0x123452B7 (lui), then 0x008000EF (jal x1,8):
  - Imm 0x12345000 with fmt=4, then 0x00000008 with fmt=5.
  - Count stays at 1 during simultaneous push and pop.
  - Pointers wrap past DEPTH-1 with no lost or duplicated entries over 10 instructions.
- Full queue with in_valid=1 and out_ready=1:
  - Exactly one pop that cycle and no push.
  - The next cycle accepts the pending instruction.
- flush_i=1 together with in_valid=1 when count=2:
  - Next cycle: count=0, out_valid=0, in_ready=1.
  - The dropped instruction never appears at the output.
- rstn=0 mid-stream when count=1:
  - Next cycle: count=0, out_valid=0.
  - Operation resumes normally after rstn=1.
